// File: rtl/fma_issue_arbiter_if.sv
// Requester/FMA bus between the issue arbiter and its users: request operands, FMA port, responses.
// Master is the requester+FMA side; slave is the arbiter.
interface fma_issue_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ*32-1:0] req_c;
    logic [31:0]           fma_a;
    logic [31:0]           fma_b;
    logic [31:0]           fma_c;
    logic [31:0]           fma_d;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_d;

    modport master (
        output req_valid, req_a, req_b, req_c, fma_d,
        input  req_ready, fma_a, fma_b, fma_c, rsp_valid, rsp_d
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, fma_d,
        output req_ready, fma_a, fma_b, fma_c, rsp_valid, rsp_d
    );
endinterface

// File: rtl/fma_issue_arbiter.sv
// Shares one pipelined FMA among NUM_REQ requesters; round-robin, or fixed priority with FMA_ARB_FIXED_PRI_EN.
// Latency: grant is combinational; the response appears LATENCY cycles after the handshake.
// Backpressure: requesters hold until granted; responses cannot be stalled; drain_req stops issue.
module fma_issue_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int LATENCY = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  drain_req,
    output logic                  drain_done,
    output logic                  busy,
    fma_issue_arbiter_if.slave    bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t               state_q, state_d;
    logic                 grant_en;
    logic                 gnt_vld;
    logic [IDW-1:0]       gnt_id;
    logic [LATENCY-1:0]   tag_vld;
    logic [IDW-1:0]       tag_id [LATENCY];

    // Reset is folded in so that every output reads zero while rst is low.
    assign grant_en = (state_q == RUN) && rst;

`ifdef FMA_ARB_FIXED_PRI_EN
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (grant_en && bus.req_valid[k]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0] ptr;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDW'(sum);
    endfunction

    // Walk downward so the candidate closest to ptr is the last one written.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (grant_en && bus.req_valid[wrap_add(ptr, k)]) begin
                gnt_vld = 1'b1;
                gnt_id  = wrap_add(ptr, k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= wrap_add(gnt_id, 1);
        end
    end
`endif

    always_comb begin
        bus.req_ready = '0;
        if (gnt_vld) bus.req_ready[gnt_id] = 1'b1;
    end

    assign bus.fma_a = gnt_vld ? bus.req_a[32*gnt_id +: 32] : 32'h0;
    assign bus.fma_b = gnt_vld ? bus.req_b[32*gnt_id +: 32] : 32'h0;
    assign bus.fma_c = gnt_vld ? bus.req_c[32*gnt_id +: 32] : 32'h0;

    // Owner tags travel alongside the FMA pipeline, one entry per FMA stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
            for (int k = 0; k < LATENCY; k++) tag_id[k] <= '0;
        end else begin
            tag_vld[0] <= gnt_vld;
            tag_id[0]  <= gnt_id;
            for (int k = 1; k < LATENCY; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    assign busy = |tag_vld;

    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_valid[i] = tag_vld[LATENCY-1] && (tag_id[LATENCY-1] == IDW'(i));
        end
    end

    assign bus.rsp_d = rst ? bus.fma_d : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_req) state_d = DRAIN;
            DRAIN: begin
                if (!drain_req) state_d = RUN;
                else if (!busy) state_d = HALT;
            end
            HALT:    if (!drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign drain_done = (state_q == HALT);
endmodule

// File: tb/tb_fma_issue_arbiter.sv
// Randomized bench for fma_issue_arbiter with a behavioural FMA and a queue-based reference model.
module tb_fma_issue_arbiter;
    localparam int N = 2;
    localparam int L = 5;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;

    logic clk = 1'b0;
    logic rst;
    logic drain_req;
    logic drain_done;
    logic busy;

    always #5 clk = ~clk;

    fma_issue_arbiter_if #(.NUM_REQ(N)) bus ();

    fma_issue_arbiter #(.NUM_REQ(N), .LATENCY(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .busy       (busy),
        .bus        (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic real sp_to_real(input logic [31:0] x);
        real v;
        int  e;
        e = int'(x[30:23]);
        if (e == 0) return 0.0;
        v = 1.0 + real'(x[22:0]) / 8388608.0;
        for (int k = 0; k < e - 127; k++) v = v * 2.0;
        for (int k = 0; k < 127 - e; k++) v = v / 2.0;
        return x[31] ? -v : v;
    endfunction

    function automatic logic [31:0] real_to_sp(input real r);
        logic       s;
        int         e;
        int         m;
        logic [7:0] ev;
        logic [22:0] mv;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        if (s) r = -r;
        e = 127;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0)  begin r = r * 2.0; e--; end
        m  = $rtoi((r - 1.0) * 8388608.0);
        ev = e[7:0];
        mv = m[22:0];
        return {s, ev, mv};
    endfunction

    function automatic logic [31:0] fma_fn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return real_to_sp(sp_to_real(a) * sp_to_real(b) + sp_to_real(c));
    endfunction

    // Behavioural FMA: LATENCY register stages, not reset.
    logic [31:0] fpipe [L];
    initial for (int k = 0; k < L; k++) fpipe[k] = 32'h0;
    always @(posedge clk) begin
        fpipe[0] <= fma_fn(bus.fma_a, bus.fma_b, bus.fma_c);
        for (int k = 1; k < L; k++) fpipe[k] <= fpipe[k-1];
    end
    assign bus.fma_d = fpipe[L-1];

    // Requester state: one pending op each, held until granted.
    logic        pend [N];
    logic [31:0] pa [N];
    logic [31:0] pb [N];
    logic [31:0] pc [N];

    // Reference model state.
    typedef struct {
        int          id;
        logic [31:0] d;
        int          due;
    } ifl_t;
    ifl_t q[$];
    int   mode;
    int   ptr;
    int   cyc;
    int   hs_cyc;
    int   obs_cyc;
    logic [31:0] obs_d;

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        pend[i] = 1'b1;
        pa[i] = a;
        pb[i] = b;
        pc[i] = c;
    endtask

    task automatic rand_op(input int i);
        int ai, bi, ci;
        ai = int'($urandom_range(14)) - 7;
        bi = int'($urandom_range(14)) - 7;
        ci = int'($urandom_range(14)) - 7;
        set_op(i, real_to_sp(real'(ai)), real_to_sp(real'(bi)), real_to_sp(real'(ci)));
    endtask

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]       = pend[i];
            bus.req_a[32*i +: 32]  = pa[i];
            bus.req_b[32*i +: 32]  = pb[i];
            bus.req_c[32*i +: 32]  = pc[i];
        end
    endtask

    task automatic tick(input logic [N-1:0] mask, input int pct, input logic drv_drain, input logic drv_rst);
        int          g;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rsp;
        logic [31:0] ea, eb, ec, exp_d;
        bit          bsy;
        ifl_t        e;
        rst       = drv_rst;
        drain_req = drv_drain;
        for (int i = 0; i < N; i++)
            if (mask[i] && !pend[i] && int'($urandom_range(99)) < pct) rand_op(i);
        drive_bus();
        @(negedge clk);
        if (!drv_rst) begin
            mode = M_RUN;
            ptr  = 0;
            q.delete();
        end
        g = -1;
        if (drv_rst && mode == M_RUN) begin
            for (int k = N - 1; k >= 0; k--) begin
`ifdef FMA_ARB_FIXED_PRI_EN
                if (pend[k]) g = k;
`else
                if (pend[(ptr + k) % N]) g = (ptr + k) % N;
`endif
            end
        end
        exp_rdy = '0;
        ea = 32'h0; eb = 32'h0; ec = 32'h0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            ea = pa[g]; eb = pb[g]; ec = pc[g];
        end
        bsy = (q.size() > 0);
        exp_rsp = '0;
        exp_d = 32'h0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_rsp[q[0].id] = 1'b1;
            exp_d = q[0].d;
        end
        chk("req_ready",  32'(bus.req_ready), 32'(exp_rdy));
        chk("fma_a",      bus.fma_a, ea);
        chk("fma_b",      bus.fma_b, eb);
        chk("fma_c",      bus.fma_c, ec);
        chk("rsp_valid",  32'(bus.rsp_valid), 32'(exp_rsp));
        chk("busy",       32'(busy), 32'(bsy));
        chk("drain_done", 32'(drain_done), 32'(mode == M_HALT));
        if (!drv_rst || exp_rsp != '0) chk("rsp_d", bus.rsp_d, exp_d);
        if (bus.rsp_valid[0]) begin
            obs_cyc = cyc;
            obs_d   = bus.rsp_d;
        end
        if (g >= 0) begin
            e.id  = g;
            e.d   = fma_fn(pa[g], pb[g], pc[g]);
            e.due = cyc + L;
            q.push_back(e);
            if (g == 0) hs_cyc = cyc;
            ptr = (g + 1) % N;
            pend[g] = 1'b0;
        end
        if (exp_rsp != '0) void'(q.pop_front());
        if (drv_rst) begin
            case (mode)
                M_RUN:   if (drv_drain) mode = M_DRAIN;
                M_DRAIN: begin
                    if (!drv_drain) mode = M_RUN;
                    else if (!bsy)  mode = M_HALT;
                end
                default: if (!drv_drain) mode = M_RUN;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [N-1:0] mask;
        int           pct;
        logic         dr;
        logic         rr;
        rst = 1'b0;
        drain_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; pa[i] = 32'h0; pb[i] = 32'h0; pc[i] = 32'h0;
        end
        drive_bus();
        mode = M_RUN; ptr = 0; cyc = 0; hs_cyc = -1; obs_cyc = -1; obs_d = 32'h0;
        @(posedge clk);
        #1;
        repeat (3) tick('0, 0, 1'b0, 1'b0);

        // Single op from R0: 1.0 * 2.0 + 3.0
        set_op(0, 32'h3F800000, 32'h40000000, 32'h40400000);
        repeat (8) tick('0, 0, 1'b0, 1'b1);
        chk("t1_latency", 32'(obs_cyc - hs_cyc), 32'(L));
        chk("t1_result",  obs_d, 32'h40A00000);

        // Both requesters saturating, then R1 back-to-back alone
        repeat (8) tick(2'b11, 100, 1'b0, 1'b1);
        repeat (6) tick('0, 0, 1'b0, 1'b1);
        repeat (5) tick(2'b10, 100, 1'b0, 1'b1);
        repeat (7) tick('0, 0, 1'b0, 1'b1);

        // Drain with ops in flight, then resume
        repeat (3) tick(2'b10, 100, 1'b0, 1'b1);
        repeat (10) tick(2'b11, 100, 1'b1, 1'b1);
        repeat (4) tick(2'b11, 100, 1'b0, 1'b1);
        repeat (8) tick('0, 0, 1'b0, 1'b1);

        // Reset two cycles after an issue
        tick(2'b01, 100, 1'b0, 1'b1);
        repeat (2) tick('0, 0, 1'b0, 1'b1);
        repeat (2) tick('0, 0, 1'b0, 1'b0);
        repeat (8) tick('0, 0, 1'b0, 1'b1);
        repeat (4) tick(2'b11, 100, 1'b0, 1'b1);

        dr = 1'b0;
        repeat (40) begin
            mask = N'($urandom);
            pct  = int'($urandom_range(100));
            repeat (50) begin
                if ($urandom_range(99) < 4) dr = ~dr;
                rr = ($urandom_range(999) < 3) ? 1'b0 : 1'b1;
                tick(mask, pct, dr, rr);
            end
        end
        repeat (10) tick('0, 0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
